alu_sequencer: RTL and testbench

- Hardware command initiator for the ALU breadboard, replacing the hand-written stimulus thread.
- Accepts (opcode, operand) commands over a valid/ready queue and drives breadboard `opcode`/`input1` one operation at a time.
- Inserts a NOOP settle cycle after each operation, captures the accumulator result and error code, and returns them over a valid/ready result port.
- Sits between the control/host logic and the breadboard; owns the accumulator-clear sequence after reset.

---
 rtl/alu_sequencer.sv | 209 ++++++++++++++++++++
 tb/tb_alu_sequencer.sv | 544 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_sequencer.sv
// alu_sequencer: hardware command initiator for the ALU breadboard.
// Commands {opcode, operand} are queued, issued one at a time, followed by a
// NOOP settle cycle, and the accumulator value and error code are returned
// over a valid/ready result port. After reset one RESET opcode clears the
// breadboard accumulator before any command is issued.
module alu_sequencer #(
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter bit          HALT_ON_ERR = 1'b1,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [3:0]       cmd_opcode,
  input  logic [31:0]      cmd_operand,
  output logic [3:0]       alu_opcode,
  output logic [31:0]      alu_input,
  input  logic [63:0]      alu_output,
  input  logic [1:0]       alu_error,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [63:0]      res_data,
  output logic [1:0]       res_error,
  output logic             err_sticky,
  input  logic             clear_err,
  output logic             busy,
  output logic [CNT_W-1:0] issue_count
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

  localparam logic [2:0] ST_INIT   = 3'd0;
  localparam logic [2:0] ST_IDLE   = 3'd1;
  localparam logic [2:0] ST_ISSUE  = 3'd2;
  localparam logic [2:0] ST_SETTLE = 3'd3;
  localparam logic [2:0] ST_RESP   = 3'd4;
  localparam logic [2:0] ST_HALT   = 3'd5;

  localparam logic [3:0] OP_NOOP  = 4'b0000;
  localparam logic [3:0] OP_RESET = 4'b1101;

  logic [2:0]       state_q, state_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      fifo_count_q, fifo_count_d;
  logic [3:0]       cur_op_q, cur_op_d;
  logic [31:0]      cur_operand_q, cur_operand_d;
  logic [63:0]      res_data_q, res_data_d;
  logic [1:0]       res_error_q, res_error_d;
  logic             err_sticky_q, err_sticky_d;
  logic [CNT_W-1:0] issue_count_q, issue_count_d;

  logic [35:0]      fifo_mem [FIFO_DEPTH];
  logic             fifo_full;
  logic             fifo_empty;
  logic             push;
  logic             pop;

  assign fifo_full  = (fifo_count_q == FULL_CNT);
  assign fifo_empty = (fifo_count_q == '0);
  // A full queue refuses commands even when a pop happens in the same cycle.
  assign cmd_ready  = !fifo_full && (state_q != ST_INIT);
  assign push       = cmd_valid && cmd_ready;

  assign res_valid   = (state_q == ST_RESP);
  assign res_data    = res_data_q;
  assign res_error   = res_error_q;
  assign err_sticky  = err_sticky_q;
  assign issue_count = issue_count_q;
  assign busy        = (state_q != ST_IDLE) || !fifo_empty;

  // Breadboard drive is a pure function of the sequencer state.
  always_comb begin
    alu_opcode = OP_NOOP;
    alu_input  = '0;
    case (state_q)
      ST_INIT: begin
        alu_opcode = OP_RESET;
        alu_input  = '0;
      end
      ST_ISSUE: begin
        alu_opcode = cur_op_q;
        alu_input  = cur_operand_q;
      end
      default: begin
        alu_opcode = OP_NOOP;
        alu_input  = '0;
      end
    endcase
  end

  // Next-state logic: sequencing, queue pointers, result capture, error flag.
  always_comb begin
    // NOTE: every variable gets its default first, so no branch leaves one unassigned and infers a latch.
    state_d       = state_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    fifo_count_d  = fifo_count_q;
    cur_op_d      = cur_op_q;
    cur_operand_d = cur_operand_q;
    res_data_d    = res_data_q;
    res_error_d   = res_error_q;
    err_sticky_d  = err_sticky_q;
    issue_count_d = issue_count_q;
    pop           = 1'b0;

    // Clear first so a set in the same cycle overrides it.
    if (clear_err) begin
      err_sticky_d = 1'b0;
    end

    case (state_q)
      ST_INIT: begin
        state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        res_error_d   = alu_error;
        issue_count_d = issue_count_q + CNT_W'(1);
        state_d       = ST_SETTLE;
      end
      ST_SETTLE: begin
        res_data_d = alu_output;
        state_d    = ST_RESP;
      end
      ST_RESP: begin
        if (res_ready) begin
          if (res_error_q != 2'b00) begin
            err_sticky_d = 1'b1;
          end
          if ((res_error_q != 2'b00) && HALT_ON_ERR) begin
            state_d = ST_HALT;
          end else if (!fifo_empty) begin
            pop     = 1'b1;
            state_d = ST_ISSUE;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_HALT: begin
        if (clear_err) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_INIT;
      end
    endcase

    // The head entry is latched only on the transition into ISSUE.
    if (pop) begin
      {cur_op_d, cur_operand_d} = fifo_mem[rd_ptr_q];
      rd_ptr_d                  = rd_ptr_q + AW'(1);
    end
    if (push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    case ({push, pop})
      2'b10:   fifo_count_d = fifo_count_q + (AW+1)'(1);
      2'b01:   fifo_count_d = fifo_count_q - (AW+1)'(1);
      default: fifo_count_d = fifo_count_q;
    endcase
  end

  // Queue storage.
  always_ff @(posedge clock) begin
    // NOTE: storage has no reset; entry validity is tracked by the pointers and count alone.
    if (push) begin
      fifo_mem[wr_ptr_q] <= {cmd_opcode, cmd_operand};
    end
  end

  // State registers; reset returns to INIT and discards queued and in-flight work.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      state_q       <= ST_INIT;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      fifo_count_q  <= '0;
      cur_op_q      <= OP_NOOP;
      cur_operand_q <= '0;
      res_data_q    <= '0;
      res_error_q   <= '0;
      err_sticky_q  <= 1'b0;
      issue_count_q <= '0;
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      fifo_count_q  <= fifo_count_d;
      cur_op_q      <= cur_op_d;
      cur_operand_q <= cur_operand_d;
      res_data_q    <= res_data_d;
      res_error_q   <= res_error_d;
      err_sticky_q  <= err_sticky_d;
      issue_count_q <= issue_count_d;
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: drives alu_sequencer against a cycle-level breadboard
// model and compares returned results with an in-order command/accumulator
// reference model.
module tb_alu_sequencer;

  localparam int CNT_W = 16;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [3:0]       cmd_opcode = 4'h0;
  logic [31:0]      cmd_operand = 32'h0;
  logic [3:0]       alu_opcode;
  logic [31:0]      alu_input;
  logic [63:0]      alu_output;
  logic [1:0]       alu_error;
  logic             res_valid;
  logic             res_ready = 1'b0;
  logic [63:0]      res_data;
  logic [1:0]       res_error;
  logic             err_sticky;
  logic             clear_err = 1'b0;
  logic             busy;
  logic [CNT_W-1:0] issue_count;

  alu_sequencer #(.FIFO_DEPTH(4), .HALT_ON_ERR(1'b1), .CNT_W(CNT_W)) dut (
    .clock(clock), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_opcode(cmd_opcode), .cmd_operand(cmd_operand),
    .alu_opcode(alu_opcode), .alu_input(alu_input),
    .alu_output(alu_output), .alu_error(alu_error),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_error(res_error),
    .err_sticky(err_sticky), .clear_err(clear_err),
    .busy(busy), .issue_count(issue_count)
  );

  always #5 clock = ~clock;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int push_cyc = 0;

  always @(posedge clock) cyc <= cyc + 1;

  // ---------------- breadboard model ----------------
  function automatic logic [63:0] alu_math(input logic [3:0] op, input logic [31:0] opd,
                                           input logic [63:0] acc);
    case (op)
      4'b0001: return acc + {32'h0, opd};
      4'b0010: return acc - {32'h0, opd};
      4'b0011: return acc * {32'h0, opd};
      4'b0100: return (opd == 32'h0) ? acc : acc / {32'h0, opd};
      4'b1101: return 64'h0;
      default: return acc;
    endcase
  endfunction

  function automatic logic [1:0] bb_err(input logic [3:0] op, input logic [31:0] opd,
                                        input bit en, input logic [31:0] inj);
    if (op == 4'b0100 && opd == 32'h0) return 2'b01;
    if (en && op != 4'b0000 && opd == inj) return 2'b10;
    return 2'b00;
  endfunction

  logic [63:0] bb_acc = 64'hDEAD_BEEF_0BAD_F00D;
  bit          inject_en = 1'b0;
  logic [31:0] inject_operand = 32'h0;

  assign alu_output = bb_acc;
  always_comb alu_error = bb_err(alu_opcode, alu_input, inject_en, inject_operand);
  always @(posedge clock) bb_acc <= alu_math(alu_opcode, alu_input, bb_acc);

  // ---------------- result monitor and reference model ----------------
  typedef struct { logic [63:0] data; logic [1:0] err; int c; } res_t;
  typedef struct { logic [3:0] op; logic [31:0] opd; } cmd_t;

  res_t        got_q[$];
  cmd_t        exp_q[$];
  logic [63:0] model_acc = 64'h0;

  always @(negedge clock) begin
    res_t r;
    if (reset && res_valid === 1'b1 && res_ready === 1'b1) begin
      r.data = res_data;
      r.err  = res_error;
      r.c    = cyc;
      got_q.push_back(r);
    end
  end

  // Each accepted command yields exactly one result, in order, carrying the
  // accumulator after that command and the error the breadboard raised for it.
  task automatic model_next(output logic [63:0] d, output logic [1:0] e);
    cmd_t c;
    if (exp_q.size() == 0) begin
      d = 64'hx;
      e = 2'bx;
    end else begin
      c         = exp_q.pop_front();
      e         = bb_err(c.op, c.opd, inject_en, inject_operand);
      model_acc = alu_math(c.op, c.opd, model_acc);
      d         = model_acc;
    end
  endtask

  // ---------------- drivers ----------------
  task automatic push_cmd(input logic [3:0] op, input logic [31:0] opd);
    int   waited;
    cmd_t c;
    waited      = 0;
    cmd_valid   = 1'b1;
    cmd_opcode  = op;
    cmd_operand = opd;
    while (cmd_ready !== 1'b1 && waited < 200) begin
      @(posedge clock); #1;
      waited++;
    end
    if (cmd_ready !== 1'b1) begin
      vectors++; miscompares++;
      $display("FAIL push_timeout: cmd_ready=%b, required 1", cmd_ready);
    end else begin
      c.op  = op;
      c.opd = opd;
      exp_q.push_back(c);
      push_cyc = cyc;
    end
    @(posedge clock); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_results(input int n, output bit ok);
    int k;
    k = 0;
    while (got_q.size() < n && k < 300) begin
      @(posedge clock); #1;
      k++;
    end
    ok = (got_q.size() >= n);
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin
      @(posedge clock); #1;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    #1 reset = 1'b0;
    idle_cycles(3);
    vectors++;
    if (alu_opcode !== 4'b1101 || alu_input !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_drive: got op=%b in=%h, required op=1101 in=0", alu_opcode, alu_input);
    end
    vectors++;
    if ({res_valid, cmd_ready, err_sticky} !== 3'b000 || issue_count !== '0 ||
        res_data !== 64'h0 || res_error !== 2'b00) begin
      miscompares++;
      $display("FAIL reset_outputs: got valid=%b ready=%b sticky=%b cnt=%0d data=%h err=%b, required all 0",
               res_valid, cmd_ready, err_sticky, issue_count, res_data, res_error);
    end
    reset = 1'b1;
    #1;
    vectors++;
    if (alu_opcode !== 4'b1101 || cmd_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL init_cycle: got op=%b ready=%b, required op=1101 ready=0", alu_opcode, cmd_ready);
    end
    @(posedge clock); #1;
    vectors++;
    if (alu_opcode !== 4'b0000 || cmd_ready !== 1'b1 || busy !== 1'b0 || issue_count !== '0) begin
      miscompares++;
      $display("FAIL idle_after_init: got op=%b ready=%b busy=%b cnt=%0d, required op=0000 ready=1 busy=0 cnt=0",
               alu_opcode, cmd_ready, busy, issue_count);
    end
    vectors++;
    if (bb_acc !== 64'h0) begin
      miscompares++;
      $display("FAIL acc_cleared: got acc=%h, required 0", bb_acc);
    end
    model_acc = 64'h0;
  endtask

  task automatic test_back_to_back();
    logic [63:0] exp_d [3];
    logic [63:0] ed;
    logic [1:0]  ee;
    int          first_push;
    bit          ok;
    exp_d[0] = 64'd3; exp_d[1] = 64'd7; exp_d[2] = 64'd12;
    got_q.delete();
    res_ready = 1'b1;
    push_cmd(4'b0001, 32'd3);
    first_push = push_cyc;
    push_cmd(4'b0001, 32'd4);
    push_cmd(4'b0001, 32'd5);
    wait_results(3, ok);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL b2b_count: got %0d results, required 3", got_q.size());
    end
    for (int i = 0; i < 3; i++) begin
      model_next(ed, ee);
      if (i < got_q.size()) begin
        vectors++;
        if (got_q[i].data !== exp_d[i] || got_q[i].err !== 2'b00) begin
          miscompares++;
          $display("FAIL b2b_result[%0d]: got data=%0d err=%b, required data=%0d err=00",
                   i, got_q[i].data, got_q[i].err, exp_d[i]);
        end
      end
    end
    if (got_q.size() >= 3) begin
      vectors++;
      if (got_q[0].c - first_push != 4) begin
        miscompares++;
        $display("FAIL first_latency: got %0d cycles, required 4", got_q[0].c - first_push);
      end
      vectors++;
      if (got_q[1].c - got_q[0].c != 3 || got_q[2].c - got_q[1].c != 3) begin
        miscompares++;
        $display("FAIL b2b_spacing: got %0d,%0d cycles, required 3,3",
                 got_q[1].c - got_q[0].c, got_q[2].c - got_q[1].c);
      end
    end
    vectors++;
    if (issue_count !== CNT_W'(3)) begin
      miscompares++;
      $display("FAIL b2b_issue_count: got %0d, required 3", issue_count);
    end
  endtask

  task automatic test_opcode_sequence();
    logic [3:0]  ops  [5];
    logic [31:0] opds [5];
    logic [63:0] exp_d [5];
    logic [63:0] ed;
    logic [1:0]  ee;
    bit          ok;
    ops[0] = 4'b1101; opds[0] = 32'd0;   exp_d[0] = 64'd0;
    ops[1] = 4'b0001; opds[1] = 32'd2;   exp_d[1] = 64'd2;
    ops[2] = 4'b0011; opds[2] = 32'd5;   exp_d[2] = 64'd10;
    ops[3] = 4'b0011; opds[3] = 32'd314; exp_d[3] = 64'd3140;
    ops[4] = 4'b0100; opds[4] = 32'd100; exp_d[4] = 64'd31;
    got_q.delete();
    res_ready = 1'b1;
    for (int i = 0; i < 5; i++) push_cmd(ops[i], opds[i]);
    wait_results(5, ok);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL seq_count: got %0d results, required 5", got_q.size());
    end
    for (int i = 0; i < 5; i++) begin
      model_next(ed, ee);
      if (i < got_q.size()) begin
        vectors++;
        if (got_q[i].data !== exp_d[i] || got_q[i].err !== 2'b00) begin
          miscompares++;
          $display("FAIL seq_result[%0d]: got data=%0d err=%b, required data=%0d err=00",
                   i, got_q[i].data, got_q[i].err, exp_d[i]);
        end
      end
    end
  endtask

  task automatic test_fill_queue();
    logic [63:0]      hold_data, hold_acc, ed;
    logic [1:0]       ee;
    logic [CNT_W-1:0] base;
    bit               ok, stable, refused;
    got_q.delete();
    res_ready = 1'b0;
    base      = issue_count;
    for (int i = 0; i < 5; i++) push_cmd(4'b0001, $urandom_range(1, 1000));
    vectors++;
    if (cmd_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL full_ready: got cmd_ready=%b, required 0", cmd_ready);
    end
    hold_data   = res_data;
    hold_acc    = bb_acc;
    stable      = 1'b1;
    refused     = 1'b1;
    cmd_valid   = 1'b1;
    cmd_opcode  = 4'b0001;
    cmd_operand = 32'h5555;
    for (int i = 0; i < 6; i++) begin
      if (cmd_ready !== 1'b0) refused = 1'b0;
      if (res_valid !== 1'b1 || res_data !== hold_data || alu_opcode !== 4'b0000 || bb_acc !== hold_acc)
        stable = 1'b0;
      @(posedge clock); #1;
    end
    cmd_valid = 1'b0;
    vectors++;
    if (!refused || issue_count !== base + CNT_W'(1)) begin
      miscompares++;
      $display("FAIL extra_push_refused: got refused=%b cnt=%0d, required refused=1 cnt=%0d",
               refused, issue_count, base + CNT_W'(1));
    end
    vectors++;
    if (!stable) begin
      miscompares++;
      $display("FAIL resp_hold: got unstable result/drive while res_ready=0, required stable");
    end
    res_ready = 1'b1;
    wait_results(5, ok);
    idle_cycles(10);
    vectors++;
    if (got_q.size() != 5) begin
      miscompares++;
      $display("FAIL fill_count: got %0d results, required 5", got_q.size());
    end
    for (int i = 0; i < 5; i++) begin
      model_next(ed, ee);
      if (i < got_q.size()) begin
        vectors++;
        if (got_q[i].data !== ed || got_q[i].err !== ee) begin
          miscompares++;
          $display("FAIL fill_result[%0d]: got data=%h err=%b, required data=%h err=%b",
                   i, got_q[i].data, got_q[i].err, ed, ee);
        end
      end
    end
    vectors++;
    if (busy !== 1'b0 || issue_count !== base + CNT_W'(5)) begin
      miscompares++;
      $display("FAIL fill_drain: got busy=%b cnt=%0d, required busy=0 cnt=%0d",
               busy, issue_count, base + CNT_W'(5));
    end
  endtask

  task automatic test_error_halt();
    logic [63:0]      ed;
    logic [1:0]       ee;
    logic [CNT_W-1:0] base;
    bit               ok, quiet;
    got_q.delete();
    res_ready      = 1'b1;
    inject_en      = 1'b1;
    inject_operand = 32'd777;
    base           = issue_count;
    push_cmd(4'b0001, 32'd10);
    push_cmd(4'b0001, 32'd777);
    push_cmd(4'b0001, 32'd20);
    push_cmd(4'b0001, 32'd30);
    wait_results(2, ok);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL err_count: got %0d results, required 2", got_q.size());
    end
    for (int i = 0; i < 2; i++) begin
      model_next(ed, ee);
      if (i < got_q.size()) begin
        vectors++;
        if (got_q[i].data !== ed || got_q[i].err !== ee) begin
          miscompares++;
          $display("FAIL err_result[%0d]: got data=%h err=%b, required data=%h err=%b",
                   i, got_q[i].data, got_q[i].err, ed, ee);
        end
      end
    end
    vectors++;
    if (err_sticky !== 1'b1) begin
      miscompares++;
      $display("FAIL sticky_set: got %b, required 1", err_sticky);
    end
    quiet = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (alu_opcode !== 4'b0000 || busy !== 1'b1 || res_valid !== 1'b0) quiet = 1'b0;
      @(posedge clock); #1;
    end
    vectors++;
    if (!quiet || got_q.size() != 2 || issue_count !== base + CNT_W'(2)) begin
      miscompares++;
      $display("FAIL halt_hold: got quiet=%b results=%0d cnt=%0d, required quiet=1 results=2 cnt=%0d",
               quiet, got_q.size(), issue_count, base + CNT_W'(2));
    end
    push_cmd(4'b0001, 32'd40);
    clear_err = 1'b1;
    @(posedge clock); #1;
    clear_err = 1'b0;
    vectors++;
    if (err_sticky !== 1'b0) begin
      miscompares++;
      $display("FAIL sticky_clear: got %b, required 0", err_sticky);
    end
    wait_results(5, ok);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL resume_count: got %0d results, required 5", got_q.size());
    end
    for (int i = 2; i < 5; i++) begin
      model_next(ed, ee);
      if (i < got_q.size()) begin
        vectors++;
        if (got_q[i].data !== ed || got_q[i].err !== ee) begin
          miscompares++;
          $display("FAIL resume_result[%0d]: got data=%h err=%b, required data=%h err=%b",
                   i, got_q[i].data, got_q[i].err, ed, ee);
        end
      end
    end
    inject_en = 1'b0;
  endtask

  task automatic test_random_stream();
    logic [3:0]  op_tab [8];
    logic [3:0]  op;
    logic [31:0] opd;
    logic [63:0] ed;
    logic [1:0]  ee;
    int          n;
    bit          ok;
    op_tab[0] = 4'b0000; op_tab[1] = 4'b0001; op_tab[2] = 4'b0010; op_tab[3] = 4'b0011;
    op_tab[4] = 4'b0100; op_tab[5] = 4'b1101; op_tab[6] = 4'b1110; op_tab[7] = 4'b1111;
    got_q.delete();
    n = 23;
    fork
      begin
        push_cmd(4'b1110, $urandom);
        push_cmd(4'b1111, $urandom);
        push_cmd(4'b0001, 32'hFFFF_FFFF);
        for (int i = 0; i < 20; i++) begin
          op = op_tab[$urandom_range(0, 7)];
          case (op)
            4'b0011: opd = $urandom_range(0, 15);
            4'b0100: opd = $urandom_range(1, 1000);
            default: opd = $urandom;
          endcase
          push_cmd(op, opd);
        end
      end
      begin
        repeat (120) begin
          @(posedge clock); #1;
          res_ready = 1'($urandom_range(0, 1));
        end
        res_ready = 1'b1;
      end
    join
    wait_results(n, ok);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL random_count: got %0d results, required %0d", got_q.size(), n);
    end
    for (int i = 0; i < n; i++) begin
      model_next(ed, ee);
      if (i < got_q.size()) begin
        vectors++;
        if (got_q[i].data !== ed || got_q[i].err !== ee) begin
          miscompares++;
          $display("FAIL random_result[%0d]: got data=%h err=%b, required data=%h err=%b",
                   i, got_q[i].data, got_q[i].err, ed, ee);
        end
      end
    end
  endtask

  task automatic test_reset_mid_op();
    logic [CNT_W-1:0] base;
    logic [63:0]      ed;
    logic [1:0]       ee;
    bit               ok;
    got_q.delete();
    res_ready = 1'b1;
    base      = issue_count;
    push_cmd(4'b0001, 32'd1);
    push_cmd(4'b0001, 32'd2);
    push_cmd(4'b0001, 32'd3);
    vectors++;
    if (alu_opcode !== 4'b0000 || res_valid !== 1'b0 || issue_count !== base + CNT_W'(1)) begin
      miscompares++;
      $display("FAIL settle_reached: got op=%b valid=%b cnt=%0d, required op=0000 valid=0 cnt=%0d",
               alu_opcode, res_valid, issue_count, base + CNT_W'(1));
    end
    reset = 1'b0;
    #1;
    exp_q.delete();
    model_acc = 64'h0;
    vectors++;
    if (res_valid !== 1'b0 || alu_opcode !== 4'b1101 || cmd_ready !== 1'b0 || issue_count !== '0) begin
      miscompares++;
      $display("FAIL mid_reset: got valid=%b op=%b ready=%b cnt=%0d, required 0/1101/0/0",
               res_valid, alu_opcode, cmd_ready, issue_count);
    end
    @(posedge clock); #1;
    reset = 1'b1;
    vectors++;
    if (alu_opcode !== 4'b1101) begin
      miscompares++;
      $display("FAIL mid_init: got op=%b, required 1101", alu_opcode);
    end
    @(posedge clock); #1;
    vectors++;
    if (alu_opcode !== 4'b0000 || busy !== 1'b0 || cmd_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL mid_idle: got op=%b busy=%b ready=%b, required 0000/0/1", alu_opcode, busy, cmd_ready);
    end
    idle_cycles(8);
    vectors++;
    if (got_q.size() != 0 || issue_count !== '0 || bb_acc !== 64'h0) begin
      miscompares++;
      $display("FAIL queue_discarded: got results=%0d cnt=%0d acc=%h, required 0/0/0",
               got_q.size(), issue_count, bb_acc);
    end
    push_cmd(4'b0001, 32'd9);
    wait_results(1, ok);
    model_next(ed, ee);
    vectors++;
    if (!ok || got_q[0].data !== ed || got_q[0].err !== ee) begin
      miscompares++;
      $display("FAIL post_reset_cmd: got ok=%b data=%h, required data=%h", ok,
               (got_q.size() > 0) ? got_q[0].data : 64'hx, ed);
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_opcode_sequence();
    test_fill_queue();
    test_error_halt();
    test_random_stream();
    test_reset_mid_op();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
